// File: rtl/repetition_serial_decoder_pkg.sv
// Shared definitions for the repetition code family: state encoding,
// vote counter sizing, majority threshold and parameter legality check.
package repetition_serial_decoder_pkg;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_OUTPUT  = 1'b1
  } state_e;

  // Bits needed to count 0..rep votes.
  function automatic int count_width(input int rep);
    return $clog2(rep + 1);
  endfunction

  // A bit decodes to 1 when its vote count exceeds this value.
  function automatic int majority_threshold(input int rep);
    return rep / 2;
  endfunction

  // Odd and at least 3 so that a majority always exists.
  function automatic bit repetition_ok(input int rep);
    return (rep >= 3) && ((rep % 2) == 1);
  endfunction

endpackage

// File: rtl/repetition_vote_counter.sv
// One bit lane of the serial repetition decoder: counts the ones seen on
// this bit position across the copies of a word and reports the majority
// and disagreement including the copy currently being presented.
module repetition_vote_counter
  import repetition_serial_decoder_pkg::*;
#(
  parameter int REPETITION = 3
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic inc_en_i,
  input  logic last_i,
  input  logic bit_i,
  output logic majority_o,
  output logic disagree_o
);

  localparam int CW  = count_width(REPETITION);
  localparam int THR = majority_threshold(REPETITION);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] total_s;

  // Running total including the incoming bit; feeds the final decision.
  always_comb begin
    total_s    = cnt_q + {{(CW-1){1'b0}}, bit_i};
    majority_o = (total_s > CW'(THR));
    disagree_o = (total_s != {CW{1'b0}}) && (total_s != CW'(REPETITION));
  end

  // Counter update: abort wins, final copy restarts the count, else accumulate.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CW{1'b0}};
    end else if (inc_en_i) begin
      if (last_i) begin
        cnt_d = {CW{1'b0}};
      end else begin
        cnt_d = total_s;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Vote counter register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/repetition_serial_decoder.sv
// Serial repetition decoder: accepts REPETITION copies of a word one per
// transfer, majority-votes each bit and presents the decoded word with a
// flag telling whether any copy disagreed.
module repetition_serial_decoder
  import repetition_serial_decoder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int REPETITION = 3
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] copy_data,
  input  logic                  copy_valid,
  output logic                  copy_ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  corrected
);

  if (!repetition_ok(REPETITION)) begin : g_bad_repetition
    $error("REPETITION must be odd and >= 3");
  end

  localparam int IW = count_width(REPETITION);

  state_e                state_q;
  state_e                state_d;
  logic [IW-1:0]         idx_q;
  logic [IW-1:0]         idx_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  corr_q;
  logic                  corr_d;
  logic                  hs_s;
  logic                  last_s;
  logic [DATA_WIDTH-1:0] maj_s;
  logic [DATA_WIDTH-1:0] dis_s;

  assign hs_s   = copy_valid & copy_ready;
  assign last_s = (idx_q == IW'(REPETITION - 1));

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_lane
    repetition_vote_counter #(
      .REPETITION (REPETITION)
    ) u_lane (
      .clock      (clock),
      .resetn     (resetn),
      .clear      (clear),
      .inc_en_i   (hs_s),
      .last_i     (last_s),
      .bit_i      (copy_data[i]),
      .majority_o (maj_s[i]),
      .disagree_o (dis_s[i])
    );
  end

  // State, copy index and decoded word registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_COLLECT;
      idx_q   <= {IW{1'b0}};
      data_q  <= {DATA_WIDTH{1'b0}};
      corr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      corr_q  <= corr_d;
    end
  end

  // Next state: collect copies until the last one, then hold the word until taken.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    corr_d  = corr_q;
    if (clear) begin
      state_d = ST_COLLECT;
      idx_d   = {IW{1'b0}};
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (hs_s) begin
            if (last_s) begin
              idx_d   = {IW{1'b0}};
              data_d  = maj_s;
              corr_d  = |dis_s;
              state_d = ST_OUTPUT;
            end else begin
              idx_d = idx_q + {{(IW-1){1'b0}}, 1'b1};
            end
          end else begin
            idx_d = idx_q;
          end
        end
        ST_OUTPUT: begin
          if (data_ready) begin
            state_d = ST_COLLECT;
          end else begin
            state_d = ST_OUTPUT;
          end
        end
        default: begin
          state_d = ST_COLLECT;
          idx_d   = {IW{1'b0}};
        end
      endcase
    end
  end

  // Outputs decode registered state only; abort and reset mask copy_ready.
  always_comb begin
    copy_ready = resetn & (state_q == ST_COLLECT) & ~clear;
    data_valid = (state_q == ST_OUTPUT);
    data       = data_q;
    corrected  = corr_q;
  end

endmodule

// File: tb/tb_repetition_serial_decoder.sv
// Scoreboard bench for repetition_serial_decoder: a default 8-bit/3-copy
// instance and a 16-bit/5-copy instance, checked against a bit-count model.
module tb_repetition_serial_decoder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        resetn;
  logic        clear;
  logic [7:0]  cd_a, d_a;
  logic        cv_a, cr_a, dv_a, drdy_a, corr_a;
  logic [15:0] cd_b, d_b;
  logic        cv_b, cr_b, dv_b, drdy_b, corr_b;

  int          checks = 0;
  int          errors = 0;
  logic [16:0] exp_a[$];
  logic [16:0] exp_b[$];
  logic [16:0] e_a, e_b;
  bit          rand_rdy = 1'b0;

  repetition_serial_decoder #(.DATA_WIDTH(8), .REPETITION(3)) dut_a (
    .clock(clock), .resetn(resetn), .clear(clear),
    .copy_data(cd_a), .copy_valid(cv_a), .copy_ready(cr_a),
    .data(d_a), .data_valid(dv_a), .data_ready(drdy_a), .corrected(corr_a)
  );

  repetition_serial_decoder #(.DATA_WIDTH(16), .REPETITION(5)) dut_b (
    .clock(clock), .resetn(resetn), .clear(clear),
    .copy_data(cd_b), .copy_valid(cv_b), .copy_ready(cr_b),
    .data(d_b), .data_valid(dv_b), .data_ready(drdy_b), .corrected(corr_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: count ones per bit position across all copies.
  function automatic logic [16:0] ref_vote(input logic [15:0] cp [5], input int rep, input int w);
    logic [15:0] d = 16'h0000;
    logic        c = 1'b0;
    for (int b = 0; b < w; b++) begin
      int ones = 0;
      for (int k = 0; k < rep; k++) ones += int'(cp[k][b]);
      d[b] = (2 * ones > rep);
      if (ones != 0 && ones != rep) c = 1'b1;
    end
    return {c, d};
  endfunction

  // Monitor A: compare every transferred word against the scoreboard.
  always @(negedge clock) begin
    if (resetn && dv_a && drdy_a) begin
      if (exp_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_a_unexpected: got 0x%0h expected none", d_a);
      end else begin
        e_a = exp_a.pop_front();
        check("data_a", {24'h0, d_a}, {24'h0, e_a[7:0]});
        check("corrected_a", {31'h0, corr_a}, {31'h0, e_a[16]});
      end
    end
  end

  // Monitor B.
  always @(negedge clock) begin
    if (resetn && dv_b && drdy_b) begin
      if (exp_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_b_unexpected: got 0x%0h expected none", d_b);
      end else begin
        e_b = exp_b.pop_front();
        check("data_b", {16'h0, d_b}, {16'h0, e_b[15:0]});
        check("corrected_b", {31'h0, corr_b}, {31'h0, e_b[16]});
      end
    end
  end

  // Random downstream backpressure.
  initial begin
    forever begin
      @(posedge clock);
      #2;
      if (rand_rdy) begin
        drdy_a = 1'($urandom_range(0, 1));
        drdy_b = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic send_copy(input int sel, input logic [15:0] d);
    int n = 0;
    if (sel == 0) begin
      cv_a = 1'b1; cd_a = d[7:0];
      while (!cr_a && n < 100) begin @(posedge clock); #1; n++; end
    end else begin
      cv_b = 1'b1; cd_b = d;
      while (!cr_b && n < 100) begin @(posedge clock); #1; n++; end
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL copy_ready_timeout: got 0 expected 1 (dut %0d)", sel);
    end
    @(posedge clock); #1;
    if (sel == 0) cv_a = 1'b0; else cv_b = 1'b0;
  endtask

  task automatic send_word(input int sel, input logic [15:0] cp [5], input int maxgap);
    int rep = (sel == 0) ? 3 : 5;
    int w   = (sel == 0) ? 8 : 16;
    logic [16:0] r = ref_vote(cp, rep, w);
    if (sel == 0) exp_a.push_back(r); else exp_b.push_back(r);
    for (int k = 0; k < rep; k++) begin
      repeat ($urandom_range(0, maxgap)) begin @(posedge clock); #1; end
      send_copy(sel, cp[k]);
    end
  endtask

  logic [15:0] cp [5];
  logic [15:0] base;
  logic [15:0] mask;
  int          sel;

  initial begin
    resetn = 1'b0; clear = 1'b0;
    cv_a = 1'b0; cd_a = 8'h00; drdy_a = 1'b1;
    cv_b = 1'b0; cd_b = 16'h0000; drdy_b = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_copy_ready_low", {31'h0, cr_a}, 32'd0);
    @(negedge clock); resetn = 1'b1;
    @(posedge clock); #1;
    check("reset_copy_ready", {31'h0, cr_a}, 32'd1);
    check("reset_data_valid", {31'h0, dv_a}, 32'd0);
    check("reset_data", {24'h0, d_a}, 32'd0);
    check("reset_corrected", {31'h0, corr_a}, 32'd0);

    // Clean word with one-cycle latency and one-cycle valid.
    cp = '{16'h00A5, 16'h00A5, 16'h00A5, 16'h0000, 16'h0000};
    send_word(0, cp, 0);
    check("clean_valid_rise", {31'h0, dv_a}, 32'd1);
    @(posedge clock); #1;
    check("clean_valid_fall", {31'h0, dv_a}, 32'd0);
    check("clean_ready_back", {31'h0, cr_a}, 32'd1);

    cp = '{16'h00A5, 16'h00A4, 16'h00A5, 16'h0000, 16'h0000};
    send_word(0, cp, 1);
    cp = '{16'h0000, 16'h000F, 16'h00F0, 16'h0000, 16'h0000};
    send_word(0, cp, 1);
    cp = '{16'h00FF, 16'h000F, 16'h00F0, 16'h0000, 16'h0000};
    send_word(0, cp, 1);

    // Backpressure: word held stable, copies refused.
    @(posedge clock); #1;
    drdy_a = 1'b0;
    cp = '{16'h005A, 16'h005B, 16'h00DA, 16'h0000, 16'h0000};
    send_word(0, cp, 3);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'h0, dv_a}, 32'd1);
      check("bp_copy_ready", {31'h0, cr_a}, 32'd0);
      check("bp_data", {24'h0, d_a}, 32'h5A);
      check("bp_corrected", {31'h0, corr_a}, 32'd1);
      cv_a = 1'b1; cd_a = 8'hFF;
      @(posedge clock); #1;
    end
    cv_a = 1'b0; drdy_a = 1'b1;
    @(posedge clock); #1;
    check("bp_ready_back", {31'h0, cr_a}, 32'd1);
    cp = '{16'h003C, 16'h003C, 16'h003C, 16'h0000, 16'h0000};
    send_word(0, cp, 2);

    // Abort via clear after two copies.
    @(posedge clock); #1;
    send_copy(0, 16'h00FF);
    send_copy(0, 16'h00FF);
    clear = 1'b1; cv_a = 1'b1; cd_a = 8'hFF;
    #1;
    check("clear_masks_ready", {31'h0, cr_a}, 32'd0);
    @(posedge clock); #1;
    clear = 1'b0; cv_a = 1'b0;
    cp = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    send_word(0, cp, 1);

    // Abort via reset pulse after two copies.
    @(posedge clock); #1;
    send_copy(0, 16'h00FF);
    send_copy(0, 16'h00FF);
    resetn = 1'b0;
    #1;
    check("rst_copy_ready", {31'h0, cr_a}, 32'd0);
    check("rst_data_valid", {31'h0, dv_a}, 32'd0);
    @(posedge clock); #1;
    resetn = 1'b1;
    send_word(0, cp, 1);

    // Five copies, two fully inverted.
    cp = '{16'h1234, 16'hEDCB, 16'h1234, 16'hEDCB, 16'h1234};
    send_word(1, cp, 1);
    @(posedge clock); #1;
    check("b_valid_fall", {31'h0, dv_b}, 32'd0);

    // Randomized traffic on both instances with random backpressure.
    rand_rdy = 1'b1;
    for (int n = 0; n < 40; n++) begin
      sel  = $urandom_range(0, 1);
      base = 16'($urandom);
      for (int k = 0; k < 5; k++) begin
        mask  = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0000;
        cp[k] = base ^ mask;
        if (sel == 0) cp[k][15:8] = 8'h00;
      end
      send_word(sel, cp, 3);
    end
    rand_rdy = 1'b0;
    drdy_a = 1'b1; drdy_b = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    check("queue_a_drained", exp_a.size(), 32'd0);
    check("queue_b_drained", exp_b.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
